// File: rtl/char_rom_pkg.sv
// Shared constants, FSM state type and row placement helper for the
// character ROM glyph controller.
package char_rom_pkg;

  localparam int GLYPH_ADDR_W = 4;
  localparam int GLYPH_W      = 64;
  localparam int GLYPH_ROW_W  = 8;
  localparam int GLYPH_ROWS   = GLYPH_W / GLYPH_ROW_W;
  localparam int OFFSET_W     = $clog2(GLYPH_W);

  typedef enum logic {
    ASSEMBLE    = 1'b0,
    COMMIT_WAIT = 1'b1
  } glyph_state_t;

  // Row 0 is the top row and sits in the most significant byte, so the
  // LSB offset of row r is (ROWS-1-r)*ROW_W.
  function automatic logic [OFFSET_W-1:0] row_offset(input logic [2:0] row);
    return OFFSET_W'((GLYPH_ROWS - 1 - int'(row)) * GLYPH_ROW_W);
  endfunction

endpackage

// File: rtl/glyph_row_assembler.sv
// Glyph assembly buffer: collects CPU row beats into one full glyph and
// is wiped back to zero once the glyph has been committed to the ROM.
module glyph_row_assembler
  import char_rom_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [2:0]             wr_row,
  input  logic [GLYPH_ROW_W-1:0] wr_data,
  input  logic                   clear,
  output logic [GLYPH_W-1:0]     glyph
);

  // Clear has priority; a write overwrites exactly one row, others keep their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph <= '0;
    end else if (clear) begin
      glyph <= '0;
    end else if (wr_en) begin
      glyph[row_offset(wr_row) +: GLYPH_ROW_W] <= wr_data;
    end
  end

endmodule

// File: rtl/char_rom_glyph_ctrl.sv
// Arbiter/sequencer in front of the writable mini character ROM.
// The renderer always wins the ROM port; CPU glyph uploads are assembled
// row by row and committed in the first cycle the renderer leaves idle.
// Optional CPU readback port is enabled by defining CHAR_ROM_READBACK_EN.
module char_rom_glyph_ctrl
  import char_rom_pkg::*;
#(
  parameter int ADDR_W = GLYPH_ADDR_W,
  parameter int DATA_W = GLYPH_W,
  parameter int ROW_W  = GLYPH_ROW_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_data_valid,
  output logic [DATA_W-1:0] vga_data,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_glyph,
  input  logic [2:0]        cpu_row,
  input  logic [ROW_W-1:0]  cpu_row_data,
  input  logic              cpu_last,
  output logic              commit_done,
`ifdef CHAR_ROM_READBACK_EN
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic              cpu_rd_ack,
  output logic [DATA_W-1:0] cpu_rd_data,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_w_en,
  output logic [DATA_W-1:0] rom_in_data,
  input  logic [DATA_W-1:0] rom_char_out
);

  glyph_state_t      state;
  logic [ADDR_W-1:0] commit_addr;
  logic              beat_accept;
  logic              commit_fire;
  logic [DATA_W-1:0] glyph_buf;

  assign beat_accept = cpu_valid && cpu_ready;
  assign commit_fire = (state == COMMIT_WAIT) && !vga_req;

  glyph_row_assembler u_assembler (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (beat_accept),
    .wr_row  (cpu_row),
    .wr_data (cpu_row_data),
    .clear   (commit_fire),
    .glyph   (glyph_buf)
  );

  assign rom_w_en    = commit_fire;
  assign rom_in_data = glyph_buf;
  assign vga_data    = rom_char_out;

`ifdef CHAR_ROM_READBACK_EN
  logic rd_grant;

  assign rd_grant    = cpu_rd_req && !vga_req && !commit_fire;
  assign cpu_rd_data = rom_char_out;

  // Port mux: renderer read, then pending commit, then CPU readback.
  always_comb begin
    rom_addr = cpu_rd_addr;
    if (vga_req)
      rom_addr = vga_addr;
    else if (state == COMMIT_WAIT)
      rom_addr = commit_addr;
  end

  // Readback data comes out of the ROM one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_rd_ack <= 1'b0;
    else        cpu_rd_ack <= rd_grant;
  end
`else
  // Port mux: renderer read has priority over the commit address.
  always_comb begin
    rom_addr = vga_req ? vga_addr : commit_addr;
  end
`endif

  // Renderer data is valid the cycle after its request, matching ROM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vga_data_valid <= 1'b0;
    else        vga_data_valid <= vga_req;
  end

  // Upload FSM: assemble rows until the last beat, then wait for a free ROM cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ASSEMBLE;
      commit_addr <= '0;
      cpu_ready   <= 1'b1;
      commit_done <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        ASSEMBLE: begin
          if (beat_accept && cpu_last) begin
            state       <= COMMIT_WAIT;
            commit_addr <= cpu_glyph;
            cpu_ready   <= 1'b0;
          end
        end
        COMMIT_WAIT: begin
          if (!vga_req) begin
            state       <= ASSEMBLE;
            cpu_ready   <= 1'b1;
            commit_done <= 1'b1;
          end
        end
        default: begin
          state     <= ASSEMBLE;
          cpu_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_rom_glyph_ctrl.sv
// Directed self-checking bench for char_rom_glyph_ctrl with a behavioural
// registered ROM. Readback checks compile in when CHAR_ROM_READBACK_EN is set.
module tb_char_rom_glyph_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_req;
  logic [3:0]  vga_addr;
  logic        vga_data_valid;
  logic [63:0] vga_data;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [3:0]  cpu_glyph;
  logic [2:0]  cpu_row;
  logic [7:0]  cpu_row_data;
  logic        cpu_last;
  logic        commit_done;
  logic [3:0]  rom_addr;
  logic        rom_w_en;
  logic [63:0] rom_in_data;
  logic [63:0] rom_char_out;
`ifdef CHAR_ROM_READBACK_EN
  logic        cpu_rd_req;
  logic [3:0]  cpu_rd_addr;
  logic        cpu_rd_ack;
  logic [63:0] cpu_rd_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] rom_mem [16];

  char_rom_glyph_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vga_req        (vga_req),
    .vga_addr       (vga_addr),
    .vga_data_valid (vga_data_valid),
    .vga_data       (vga_data),
    .cpu_valid      (cpu_valid),
    .cpu_ready      (cpu_ready),
    .cpu_glyph      (cpu_glyph),
    .cpu_row        (cpu_row),
    .cpu_row_data   (cpu_row_data),
    .cpu_last       (cpu_last),
    .commit_done    (commit_done),
`ifdef CHAR_ROM_READBACK_EN
    .cpu_rd_req     (cpu_rd_req),
    .cpu_rd_addr    (cpu_rd_addr),
    .cpu_rd_ack     (cpu_rd_ack),
    .cpu_rd_data    (cpu_rd_data),
`endif
    .rom_addr       (rom_addr),
    .rom_w_en       (rom_w_en),
    .rom_in_data    (rom_in_data),
    .rom_char_out   (rom_char_out)
  );

  always #5 clk = ~clk;

  // Behavioural ROM: registered read returning the old entry on a write cycle.
  always @(posedge clk) begin
    if (rom_w_en) rom_mem[rom_addr] <= rom_in_data;
    rom_char_out <= rom_mem[rom_addr];
  end

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 64'h0;
    rom_mem[6]   = 64'h307030303030FC00;
    rom_mem[8]   = 64'h0000780C7CCC7600;
    rom_char_out = 64'h0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [3:0] glyph,
                                input logic [2:0] row, input logic [7:0] data,
                                input logic last);
    cpu_valid    = valid;
    cpu_glyph    = glyph;
    cpu_row      = row;
    cpu_row_data = data;
    cpu_last     = last;
  endtask

  task automatic vga_read(input logic [3:0] addr, input logic [63:0] expected,
                          input string tag);
    vga_req  = 1'b1;
    vga_addr = addr;
    step();
    vga_req = 1'b0;
    check_output({tag, "_valid"}, 64'(vga_data_valid), 64'h1);
    check_output({tag, "_data"}, vga_data, expected);
  endtask

  initial begin
    logic [7:0] rows [8];
    rows = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    rst_n    = 1'b0;
    vga_req  = 1'b0;
    vga_addr = 4'd0;
    apply_stimulus(1'b0, 4'd0, 3'd0, 8'h00, 1'b0);
`ifdef CHAR_ROM_READBACK_EN
    cpu_rd_req  = 1'b0;
    cpu_rd_addr = 4'd0;
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state
    check_output("rst_w_en", 64'(rom_w_en), 64'h0);
    check_output("rst_valid", 64'(vga_data_valid), 64'h0);
    check_output("rst_ready", 64'(cpu_ready), 64'h1);
    check_output("rst_done", 64'(commit_done), 64'h0);
    check_output("rst_buf", rom_in_data, 64'h0);

    // Simple renderer fetch of preloaded glyph 6
    vga_req  = 1'b1;
    vga_addr = 4'd6;
    #1;
    check_output("rd6_addr", 64'(rom_addr), 64'h6);
    step();
    vga_req = 1'b0;
    check_output("rd6_valid", 64'(vga_data_valid), 64'h1);
    check_output("rd6_data", vga_data, 64'h307030303030FC00);
    step();
    check_output("rd6_valid_drop", 64'(vga_data_valid), 64'h0);

    // Full upload of glyph 3
    for (int r = 0; r < 8; r++) begin
      apply_stimulus(1'b1, 4'd3, 3'(r), rows[r], r == 7);
      step();
    end
    apply_stimulus(1'b0, 4'd0, 3'd0, 8'h00, 1'b0);
    #1;
    check_output("g3_ready", 64'(cpu_ready), 64'h0);
    check_output("g3_w_en", 64'(rom_w_en), 64'h1);
    check_output("g3_addr", 64'(rom_addr), 64'h3);
    check_output("g3_data", rom_in_data, 64'h1122334455667788);
    step();
    check_output("g3_done", 64'(commit_done), 64'h1);
    check_output("g3_w_en_off", 64'(rom_w_en), 64'h0);
    check_output("g3_ready_back", 64'(cpu_ready), 64'h1);
    check_output("g3_buf_clear", rom_in_data, 64'h0);
    vga_read(4'd3, 64'h1122334455667788, "g3_readback");
    check_output("g3_done_pulse", 64'(commit_done), 64'h0);

    // Commit blocked by continuous renderer traffic
    apply_stimulus(1'b1, 4'd5, 3'd0, 8'hA5, 1'b1);
    step();
    apply_stimulus(1'b0, 4'd0, 3'd0, 8'h00, 1'b0);
    vga_req  = 1'b1;
    vga_addr = 4'd6;
    for (int i = 0; i < 20; i++) begin
      #1;
      check_output("blk_w_en", 64'(rom_w_en), 64'h0);
      check_output("blk_ready", 64'(cpu_ready), 64'h0);
      step();
    end
    check_output("blk_vga_data", vga_data, 64'h307030303030FC00);
    vga_req = 1'b0;
    #1;
    check_output("blk_release_w_en", 64'(rom_w_en), 64'h1);
    check_output("blk_release_addr", 64'(rom_addr), 64'h5);
    check_output("blk_release_data", rom_in_data, 64'hA500000000000000);
    step();
    check_output("blk_done", 64'(commit_done), 64'h1);
    vga_read(4'd5, 64'hA500000000000000, "g5_readback");

    // Partial glyph 15
    apply_stimulus(1'b1, 4'd15, 3'd0, 8'hFF, 1'b0);
    step();
    apply_stimulus(1'b1, 4'd15, 3'd2, 8'h81, 1'b1);
    step();
    apply_stimulus(1'b0, 4'd0, 3'd0, 8'h00, 1'b0);
    #1;
    check_output("g15_w_en", 64'(rom_w_en), 64'h1);
    check_output("g15_addr", 64'(rom_addr), 64'hF);
    check_output("g15_data", rom_in_data, 64'hFF00810000000000);
    step();
    vga_read(4'd15, 64'hFF00810000000000, "g15_readback");

    // Fresh buffer after commit; repeated row keeps last value
    apply_stimulus(1'b1, 4'd14, 3'd7, 8'h11, 1'b0);
    step();
    apply_stimulus(1'b1, 4'd14, 3'd7, 8'h5A, 1'b1);
    step();
    apply_stimulus(1'b0, 4'd0, 3'd0, 8'h00, 1'b0);
    #1;
    check_output("g14_data", rom_in_data, 64'h000000000000005A);
    check_output("g14_addr", 64'(rom_addr), 64'hE);
    step();
    check_output("g14_done", 64'(commit_done), 64'h1);

    // Reset while a commit for glyph 0 is pending
    for (int r = 0; r < 4; r++) begin
      apply_stimulus(1'b1, 4'd0, 3'(r), 8'hDE, 1'b0);
      step();
    end
    vga_req  = 1'b1;
    vga_addr = 4'd6;
    apply_stimulus(1'b1, 4'd0, 3'd4, 8'hAD, 1'b1);
    step();
    apply_stimulus(1'b0, 4'd0, 3'd0, 8'h00, 1'b0);
    vga_req = 1'b0;
    #1;
    check_output("rstmid_pending_w_en", 64'(rom_w_en), 64'h1);
    rst_n = 1'b0;
    #1;
    check_output("rstmid_async_w_en", 64'(rom_w_en), 64'h0);
    check_output("rstmid_async_ready", 64'(cpu_ready), 64'h1);
    step();
    rst_n = 1'b1;
    step();
    check_output("rstmid_buf", rom_in_data, 64'h0);
    check_output("rstmid_done", 64'(commit_done), 64'h0);
    vga_read(4'd0, 64'h0000000000000000, "g0_readback");

`ifdef CHAR_ROM_READBACK_EN
    // CPU readback starved by the renderer, then served
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 4'd8;
    vga_req     = 1'b1;
    vga_addr    = 4'd6;
    for (int i = 0; i < 6; i++) begin
      step();
      check_output("rb_no_ack", 64'(cpu_rd_ack), 64'h0);
    end
    vga_req = 1'b0;
    #1;
    check_output("rb_addr", 64'(rom_addr), 64'h8);
    step();
    cpu_rd_req = 1'b0;
    check_output("rb_ack", 64'(cpu_rd_ack), 64'h1);
    check_output("rb_data", cpu_rd_data, 64'h0000780C7CCC7600);
    step();
    check_output("rb_ack_drop", 64'(cpu_rd_ack), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
